// File: rtl/nn_mem_pkg.sv
// Shared types for the ArtNN data-memory responder.
package nn_mem_pkg;

   // Default widths match the CPU's data bus and ALU2 address result.
   localparam int unsigned DefDataW = 32;
   localparam int unsigned DefAddrW = 32;

   // Responder sequencing: wait for work, count out latency, offer load data.
   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StResp
   } state_e;

   // Request as issued by the CPU at default widths.
   typedef struct packed {
      logic                we;
      logic [DefAddrW-1:0] addr;
      logic [DefDataW-1:0] wdata;
   } dmem_req_t;

endpackage

// File: rtl/nn_req_fifo.sv
// In-order request queue; no bypass, so a pushed entry is visible at the head one cycle later.
module nn_req_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [Width-1:0] head_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [PtrW-1:0] PtrOne   = 1;
   localparam logic [PtrW:0]   CntOne   = 1;
   localparam logic [PtrW:0]   DepthCnt = Depth[PtrW:0];

   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]    count_q;
   logic [Width-1:0] store_q [Depth];
   logic             do_push, do_pop;

   assign full_o  = (count_q == DepthCnt);
   assign empty_o = (count_q == '0);
   assign head_o  = store_q[rd_ptr_q];

   // Guard both sides so the pointers can never overrun or underrun.
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Pointer and occupancy state; pointers wrap naturally since Depth is a power of two.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CntOne;
            2'b01:   count_q <= count_q - CntOne;
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage needs no reset; occupancy alone defines validity.
   always_ff @(posedge CLK) begin
      if (RST_N && do_push) begin
         store_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/nn_dmem_responder.sv
// Data-memory responder: queues CPU load/store requests and executes them in order
// against a local word array with a fixed access latency.
module nn_dmem_responder
   import nn_mem_pkg::*;
#(
   parameter int unsigned DATA_W     = DefDataW,
   parameter int unsigned ADDR_W     = DefAddrW,
   parameter int unsigned MEM_WORDS  = 256,
   parameter int unsigned LAT        = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int unsigned ReqW = 1 + ADDR_W + DATA_W;
   localparam logic [ADDR_W-1:0] MemWordsA = ADDR_W'(MEM_WORDS);
   localparam logic [3:0] LatM1 = 4'(LAT - 1);

   // Same layout as dmem_req_t, but sized by this instance's parameters.
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   req_t              push_req, head_req;
   req_t              cur_q, cur_d;
   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] mem_q [MEM_WORDS];

   logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
   logic              mem_we, in_range;
   logic [IdxW-1:0]   idx;
   logic [ReqW-1:0]   head_flat;

   // Holding req_ready low through reset keeps the CPU from pushing into a queue being cleared.
   assign req_ready = RST_N & ~fifo_full;
   assign fifo_push = req_valid & req_ready;
   assign push_req  = '{we: req_we, addr: req_addr, wdata: req_wdata};
   assign head_req  = req_t'(head_flat);

   nn_req_fifo #(
      .Width (ReqW),
      .Depth (FIFO_DEPTH)
   ) u_req_fifo (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .push_i  (fifo_push),
      .wdata_i (push_req),
      .pop_i   (fifo_pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (head_flat)
   );

   // Range check on the full address so aliases above MEM_WORDS are rejected, not wrapped.
   assign in_range = (cur_q.addr < MemWordsA);
   assign idx      = cur_q.addr[IdxW-1:0];

   assign rsp_valid = (state_q == StResp);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   // Next-state sequencing: pop, count latency down, then execute or respond.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cur_d    = cur_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      fifo_pop = 1'b0;
      mem_we   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               cur_d    = head_req;
               cnt_d    = LatM1;
               state_d  = StAccess;
            end
         end
         StAccess: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (cur_q.we) begin
               // Out-of-range stores are dropped without any indication.
               mem_we  = in_range;
               state_d = StIdle;
            end else begin
               rdata_d = in_range ? mem_q[idx] : '0;
               err_d   = ~in_range;
               state_d = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Control and response registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         cur_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cur_q   <= cur_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Word array survives reset; a write due on a reset edge is suppressed.
   always_ff @(posedge CLK) begin
      if (RST_N && mem_we) begin
         mem_q[idx] <= cur_q.wdata;
      end
   end

endmodule

// File: tb/tb_nn_dmem_responder.sv
// Directed bench for nn_dmem_responder with an in-order memory/response model.
module tb_nn_dmem_responder;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_ready = 1'b1;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [31:0] d;
      logic        e;
   } exp_t;

   logic [31:0] mdl_mem [256];
   exp_t        expq[$];
   logic        discard_next = 1'b0;

   always #5 CLK = ~CLK;

   nn_dmem_responder dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Model: memory is updated in request order; each load's answer is fixed when it is accepted.
   always @(negedge CLK) begin
      exp_t e;
      if (!RST_N) begin
         expq.delete();
      end else begin
         if (rsp_valid) begin
            if (expq.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL rsp_unexpected: got rsp_valid=1 data 0x%08h, want no response",
                        rsp_rdata);
            end else begin
               check("rsp_rdata", rsp_rdata, expq[0].d);
               check("rsp_err", {31'b0, rsp_err}, {31'b0, expq[0].e});
               if (rsp_ready) void'(expq.pop_front());
            end
         end
         if (req_valid && req_ready) begin
            if (req_we) begin
               if (discard_next) discard_next = 1'b0;
               else if (req_addr < 256) mdl_mem[req_addr[7:0]] = req_wdata;
            end else begin
               if (req_addr < 256) e = '{d: mdl_mem[req_addr[7:0]], e: 1'b0};
               else e = '{d: 32'h0, e: 1'b1};
               expq.push_back(e);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Present a request and hold it until it is taken; returns 1ns after the accepting edge.
   task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd);
      logic ok;
      ok = 1'b0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge CLK);
         ok = req_ready;
         @(posedge CLK);
         #1;
      end
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: got req_ready=0 for 200 cycles, want acceptance");
      end
      req_valid = 1'b0;
   endtask

   // Returns at a falling edge where rsp_valid is high.
   task automatic wait_valid();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge CLK);
         seen = rsp_valid;
      end
      if (!seen) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_valid: got rsp_valid=0 for 50 cycles, want 1");
      end
   endtask

   task automatic get_rsp(output logic [31:0] d, output logic e);
      rsp_ready = 1'b1;
      wait_valid();
      d = rsp_rdata;
      e = rsp_err;
      @(posedge CLK);
      #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      logic        e;

      // Reset values
      @(negedge CLK);
      check("rst_req_ready", {31'b0, req_ready}, 32'h0);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
      idle(2);
      RST_N = 1'b1;
      @(negedge CLK);
      check("post_rst_req_ready", {31'b0, req_ready}, 32'h1);
      @(posedge CLK);
      #1;

      // Store then load addr 5; valid is first seen at the 4th edge after acceptance
      send(1'b1, 32'd5, 32'hDEADBEEF);
      idle(5);
      send(1'b0, 32'd5, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge CLK);
         check($sformatf("lat_valid_edge%0d", k), {31'b0, rsp_valid}, {31'b0, k == 4});
      end
      check("lat_rdata", rsp_rdata, 32'hDEADBEEF);
      check("lat_err", {31'b0, rsp_err}, 32'h0);
      @(negedge CLK);
      check("lat_valid_drop", {31'b0, rsp_valid}, 32'h0);
      @(posedge CLK);
      #1;

      // Back-pressure: a stalled load blocks the engine while four stores fill the queue
      rsp_ready = 1'b0;
      send(1'b0, 32'd5, 32'h0);
      wait_valid();
      @(posedge CLK);
      #1;
      for (int i = 0; i < 4; i++) send(1'b1, i, 32'h10 + i);
      @(negedge CLK);
      check("bp_full_ready", {31'b0, req_ready}, 32'h0);
      @(posedge CLK);
      #1;
      rsp_ready = 1'b1;
      @(negedge CLK);
      check("bp_ready_hs", {31'b0, req_ready}, 32'h0);
      @(negedge CLK);
      check("bp_ready_idle", {31'b0, req_ready}, 32'h0);
      @(negedge CLK);
      check("bp_ready_after_pop", {31'b0, req_ready}, 32'h1);
      @(posedge CLK);
      #1;
      idle(20);
      send(1'b0, 32'd0, 32'h0);
      send(1'b0, 32'd1, 32'h0);
      send(1'b0, 32'd3, 32'h0);
      idle(20);

      // Response stall on addr 2
      rsp_ready = 1'b0;
      send(1'b0, 32'd2, 32'h0);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", {31'b0, rsp_valid}, 32'h1);
         check("stall_rdata", rsp_rdata, 32'h12);
         @(negedge CLK);
      end
      @(posedge CLK);
      #1;
      rsp_ready = 1'b1;
      @(negedge CLK);
      check("stall_valid_at_hs", {31'b0, rsp_valid}, 32'h1);
      @(negedge CLK);
      check("stall_valid_after_hs", {31'b0, rsp_valid}, 32'h0);
      @(posedge CLK);
      #1;

      // Out-of-range store must not alias onto addr 44
      send(1'b1, 32'd44, 32'h44);
      send(1'b1, 32'd300, 32'h55);
      rsp_ready = 1'b0;
      send(1'b0, 32'd300, 32'h0);
      get_rsp(d, e);
      check("oor_rdata", d, 32'h0);
      check("oor_err", {31'b0, e}, 32'h1);
      send(1'b0, 32'd44, 32'h0);
      get_rsp(d, e);
      check("alias_rdata", d, 32'h44);
      check("alias_err", {31'b0, e}, 32'h0);

      // Ordering through the queue
      send(1'b1, 32'd7, 32'hA);
      send(1'b0, 32'd7, 32'h0);
      send(1'b1, 32'd7, 32'hB);
      send(1'b0, 32'd7, 32'h0);
      get_rsp(d, e);
      check("order_first", d, 32'hA);
      get_rsp(d, e);
      check("order_second", d, 32'hB);

      // Reset while a store to addr 9 is in its access latency
      rsp_ready = 1'b1;
      send(1'b1, 32'd9, 32'h77);
      idle(6);
      discard_next = 1'b1;
      send(1'b1, 32'd9, 32'h99);
      idle(1);
      RST_N = 1'b0;
      idle(2);
      RST_N = 1'b1;
      @(negedge CLK);
      check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      check("midrst_req_ready", {31'b0, req_ready}, 32'h1);
      @(posedge CLK);
      #1;
      idle(6);
      rsp_ready = 1'b0;
      send(1'b0, 32'd9, 32'h0);
      get_rsp(d, e);
      check("midrst_addr9", d, 32'h77);
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
